sram_1r1w_init_ext: RTL
=======================

Name: sram_1r1w_init_ext

Overview:
- Parametrised behavioural SRAM model with one read port and one write port on a single clock, successor to the single-port masked-write array models.
- Adds a hardware init sweep after reset and on a software clear, a registered read-data hold, configurable read-during-write bypass, and out-of-range address protection.
- Used as the macro stand-in for tag/data arrays that need a known post-reset state without a RANDOMIZE flow.

Parameters:
DEPTH, 1024, number of entries (any value 1..2^ADDR_W)
ADDR_W, 10, address width
DATA_W, 70, data width
GRAN_W, 7, write-mask granule width; DATA_W must be a multiple of GRAN_W; MASK_W = DATA_W/GRAN_W
INIT_VAL, 0, DATA_W-bit value written to every entry by the init sweep
BYPASS, 1, 1 = a read colliding with a write returns the post-write data; 0 = it returns the pre-write data

Ports:
clock  in  1  clock, all logic rising-edge
reset_n  in  1  asynchronous active-low reset
clear  in  1  pulse; restarts the init sweep (accepted only in READY)
init_done  out  1  high in READY; port requests are ignored while low
r_en  in  1  read request
r_addr  in  ADDR_W  read address
r_valid  out  1  r_rdata updated from a read accepted in the previous cycle
r_rdata  out  DATA_W  registered read data, held until the next accepted read
w_en  in  1  write request
w_addr  in  ADDR_W  write address
w_mask  in  MASK_W  per-granule write enable; bit i covers data[i*GRAN_W +: GRAN_W]
w_data  in  DATA_W  write data

Behaviour:
- Reset (reset_n low, asynchronous): state=INIT, init counter=0, init_done=0, r_valid=0, r_rdata=0. Array contents are not reset directly.
- INIT: each cycle writes INIT_VAL to the entry at the counter, then increments the counter. After writing entry DEPTH-1, the next state is READY and init_done=1. The sweep takes exactly DEPTH cycles after reset release.
- During INIT, r_en and w_en are ignored: no array write, r_valid=0, r_rdata holds its value. clear is ignored.
- READY: a read is accepted when r_en=1. r_rdata is loaded at the next clock edge, so the data appears 1 cycle after the request. r_valid=1 for that one cycle only.
- Without an accepted read, r_valid=0 and r_rdata holds its value.
- A write is accepted when w_en=1. Only granules whose w_mask bit is set are updated. w_mask=0 is a no-op.
- Read and write in the same cycle at the same address:
  - BYPASS=1: r_rdata equals the old data with the masked granules replaced by w_data.
  - BYPASS=0: r_rdata equals the old data.
  - The array is updated in both cases.
- Out-of-range address (addr >= DEPTH): the write is dropped. An out-of-range read is still accepted with r_valid=1 and r_rdata=0.
- clear=1 in READY: the next state is INIT, the counter is reset to 0 and init_done drops on the next edge.
- A read or write issued in the same cycle as clear is still performed; its r_valid/r_rdata arrive in the first INIT cycle.
- reset_n asserted mid-sweep: the sweep restarts from entry 0 after release.
- Only the two states INIT and READY exist. The counter is clog2(DEPTH)+1 bits wide and never wraps.

Test Plan:
- DEPTH=16, INIT_VAL=70'h155: release reset -> init_done rises exactly 16 cycles later. Reading every address then returns 70'h155, each with r_valid 1 cycle after r_en.
- Masked write to addr 3 with w_mask=10'b0000000011, w_data all-ones -> reading addr 3 returns bits[13:0]=all-ones and bits[69:14]=INIT_VAL[69:14].
- Collision at addr 5 (old=0, w_mask=all, w_data=70'h3FF) -> BYPASS=1 gives r_rdata=70'h3FF; BYPASS=0 gives 0. A read of addr 5 on the following cycle gives 70'h3FF in both builds.
- Requests during INIT: write 70'h1 to addr 2 at cycle 4 of the sweep -> no r_valid; after init_done, addr 2 reads INIT_VAL.
- DEPTH=12, ADDR_W=4: write addr 14 -> no array entry changes; reading addr 14 gives r_valid=1, r_rdata=0.
- Pulse clear after writing addr 0 -> init_done low for 16 cycles, then addr 0 reads INIT_VAL. Asserting reset_n low at sweep cycle 7 restarts the sweep, and init_done rises 16 cycles after release.

Source files
------------

// File: rtl/sram_1r1w_init_ext_if.sv
// ---------------------------------------------------------------------------
// sram_1r1w_init_ext_if
//
// Request/response bundle for the sram_1r1w_init_ext array model.
//
// Signals:
//   clear      master->slave  pulse that restarts the init sweep
//   init_done  slave->master  high once the array holds a known state
//   r_en       master->slave  read request
//   r_addr     master->slave  read address
//   r_valid    slave->master  r_rdata was loaded by last cycle's read
//   r_rdata    slave->master  registered read data, held between reads
//   w_en       master->slave  write request
//   w_addr     master->slave  write address
//   w_mask     master->slave  per-granule write enable
//   w_data     master->slave  write data
//
// Modports:
//   master  the requester side (testbench or pipeline logic)
//   slave   the array model itself
// ---------------------------------------------------------------------------
interface sram_1r1w_init_ext_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 70,
    parameter int MASK_W = 10
);

    logic              clear;
    logic              init_done;
    logic              r_en;
    logic [ADDR_W-1:0] r_addr;
    logic              r_valid;
    logic [DATA_W-1:0] r_rdata;
    logic              w_en;
    logic [ADDR_W-1:0] w_addr;
    logic [MASK_W-1:0] w_mask;
    logic [DATA_W-1:0] w_data;

    modport master (
        output clear,
        output r_en,
        output r_addr,
        output w_en,
        output w_addr,
        output w_mask,
        output w_data,
        input  init_done,
        input  r_valid,
        input  r_rdata
    );

    modport slave (
        input  clear,
        input  r_en,
        input  r_addr,
        input  w_en,
        input  w_addr,
        input  w_mask,
        input  w_data,
        output init_done,
        output r_valid,
        output r_rdata
    );

endinterface

// File: rtl/sram_1r1w_init_ext.sv
// ---------------------------------------------------------------------------
// sram_1r1w_init_ext
//
// Behavioural one-read/one-write SRAM used as a stand-in for tag/data array
// macros. After reset (or a clear pulse) a hardware sweep writes INIT_VAL to
// every entry, so the array has a known state without any randomisation
// flow. Port requests are ignored until the sweep finishes.
//
// Ports:
//   clock    rising-edge clock for all logic
//   reset_n  asynchronous active-low reset
//   bus      sram_1r1w_init_ext_if slave modport:
//              clear / init_done        init sweep control and status
//              r_en / r_addr            read request
//              r_valid / r_rdata        registered read response (1 cycle)
//              w_en / w_addr / w_mask / w_data   masked write request
//
// Read latency is one cycle. A read colliding with a write to the same
// address returns post-write data when BYPASS=1, pre-write data when
// BYPASS=0. Out-of-range writes are dropped; out-of-range reads return 0.
// ---------------------------------------------------------------------------
module sram_1r1w_init_ext #(
    parameter int               DEPTH    = 1024,
    parameter int               ADDR_W   = 10,
    parameter int               DATA_W   = 70,
    parameter int               GRAN_W   = 7,
    parameter logic [DATA_W-1:0] INIT_VAL = '0,
    parameter bit               BYPASS   = 1'b1
) (
    input  logic                   clock,
    input  logic                   reset_n,
    sram_1r1w_init_ext_if.slave    bus
);

    localparam int MASK_W = DATA_W / GRAN_W;
    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // One bit wider than the address so DEPTH = 2^ADDR_W is representable.
    localparam logic [ADDR_W:0]    DEPTH_LIM = (ADDR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0]   LAST_IDX  = CNT_W'(DEPTH - 1);

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   init_cnt;
    logic [CNT_W-1:0]   init_cnt_nxt;

    logic [DATA_W-1:0]  mem [DEPTH];

    logic               ready;
    logic               rd_in_range;
    logic               wr_in_range;
    logic               rd_accept;
    logic               wr_accept;
    logic [IDX_W-1:0]   rd_idx;
    logic [IDX_W-1:0]   wr_idx;

    logic               mem_we;
    logic [IDX_W-1:0]   mem_widx;
    logic [MASK_W-1:0]  mem_wmask;
    logic [DATA_W-1:0]  mem_wdata;

    logic [DATA_W-1:0]  rd_old;
    logic [DATA_W-1:0]  rd_data;

    logic               r_valid_q;
    logic [DATA_W-1:0]  r_rdata_q;

    // State and sweep counter registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_INIT;
            init_cnt <= '0;
        end else begin
            state    <= state_nxt;
            init_cnt <= init_cnt_nxt;
        end
    end

    // Sweep sequencing: step through every entry once, then sit in READY
    // until a clear restarts the sweep. The counter stops advancing in READY
    // so it never wraps.
    always_comb begin
        state_nxt    = state;
        init_cnt_nxt = init_cnt;
        case (state)
            ST_INIT: begin
                init_cnt_nxt = init_cnt + CNT_W'(1);
                if (init_cnt == LAST_IDX) begin
                    state_nxt = ST_READY;
                end
            end
            ST_READY: begin
                if (bus.clear) begin
                    state_nxt    = ST_INIT;
                    init_cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt    = ST_INIT;
                init_cnt_nxt = '0;
            end
        endcase
    end

    // Request qualification. Requests in the clear cycle are still served
    // because the state is still READY in that cycle.
    always_comb begin
        ready       = (state == ST_READY);
        rd_in_range = ({1'b0, bus.r_addr} < DEPTH_LIM);
        wr_in_range = ({1'b0, bus.w_addr} < DEPTH_LIM);
        rd_accept   = ready && bus.r_en;
        wr_accept   = ready && bus.w_en && wr_in_range;
        rd_idx      = IDX_W'(bus.r_addr);
        wr_idx      = IDX_W'(bus.w_addr);
    end

    // The single array write port is shared between the init sweep and
    // user writes; the two never overlap since user writes need READY.
    always_comb begin
        mem_we    = 1'b0;
        mem_widx  = '0;
        mem_wmask = '0;
        mem_wdata = '0;
        if (!ready) begin
            mem_we    = 1'b1;
            mem_widx  = IDX_W'(init_cnt);
            mem_wmask = '1;
            mem_wdata = INIT_VAL;
        end else if (wr_accept) begin
            mem_we    = 1'b1;
            mem_widx  = wr_idx;
            mem_wmask = bus.w_mask;
            mem_wdata = bus.w_data;
        end
    end

    // Array storage, deliberately not reset: the sweep gives it a known
    // state instead.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            for (int g = 0; g < MASK_W; g++) begin
                if (mem_wmask[g]) begin
                    mem[mem_widx][g*GRAN_W +: GRAN_W] <= mem_wdata[g*GRAN_W +: GRAN_W];
                end
            end
        end
    end

    // Read data selection. Out-of-range reads never touch the array and
    // return zero. On a same-address collision with BYPASS set, the written
    // granules are merged over the stored word so the read sees the result
    // of this cycle's write.
    always_comb begin
        rd_old  = rd_in_range ? mem[rd_idx] : '0;
        rd_data = rd_old;
        if (BYPASS && rd_accept && wr_accept && (bus.r_addr == bus.w_addr)) begin
            for (int g = 0; g < MASK_W; g++) begin
                if (bus.w_mask[g]) begin
                    rd_data[g*GRAN_W +: GRAN_W] = bus.w_data[g*GRAN_W +: GRAN_W];
                end
            end
        end
    end

    // Registered read response: valid pulses for one cycle per accepted
    // read, data holds until the next accepted read.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_valid_q <= 1'b0;
            r_rdata_q <= '0;
        end else begin
            r_valid_q <= rd_accept;
            if (rd_accept) begin
                r_rdata_q <= rd_data;
            end
        end
    end

    assign bus.init_done = ready;
    assign bus.r_valid   = r_valid_q;
    assign bus.r_rdata   = r_rdata_q;

endmodule
